branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor that drives the PC register's PCSrc and TargetAddr inputs. It combinationally decodes InstrF at PCF, looks up a table of 2-bit saturating counters, and requests a predicted-taken redirect. It also accepts branch resolution from Execute to train the table and to request a misprediction redirect to PCNextE.

Parameters:
IDX_BITS, 6, log2 of BHT entries (64 counters)
GHR_BITS, 6, global history length; only used with BP_GSHARE_EN; must be <= IDX_BITS

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
PCF  input  32  fetch PC
InstrF  input  32  instruction fetched at PCF
BranchE  input  1  conditional branch resolving in Execute this cycle
TakenE  input  1  resolved direction of that branch
PredTakenE  input  1  prediction carried down the pipe for that branch
JalrE  input  1  JALR in Execute (always redirects)
BhtIdxE  input  IDX_BITS  table index carried down the pipe for that branch
PCSrc  output  2  00 sequential, 01 predicted taken, 10 mispredict redirect
TargetAddr  output  32  predicted target for PCSrc=01
PredTakenF  output  1  prediction for InstrF, to be pipelined
BhtIdxF  output  IDX_BITS  index used for InstrF, to be pipelined

Behaviour:
- Decode: opcode 7'b1100011 is a B-type branch; opcode 7'b1101111 is JAL; every other opcode is not predicted.
- Targets: B-type TargetAddr = PCF + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). JAL TargetAddr = PCF + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). Arithmetic is modulo 2^32 and wraps silently. For non-control instructions TargetAddr = PCF + 4.
- Index: BhtIdxF = PCF[IDX_BITS+1:2].
- Counters: states SNT=00, WNT=01, WT=10, ST=11. Predict taken when the counter MSB is 1.
- PredTakenF: 1 for JAL; counter MSB for a B-type branch; 0 otherwise.
- PCSrc priority:
  - 10 if (BranchE && TakenE!=PredTakenE) || JalrE.
  - else 01 if PredTakenF.
  - else 00.
  - Execute redirect always wins over a fetch prediction in the same cycle.
- Training: on the rising clk edge with BranchE=1, counter[BhtIdxE] saturating-increments if TakenE, else saturating-decrements. 11 stays 11 on taken; 00 stays 00 on not-taken. JAL and JALR never train.
- Read/update collision (same index, same cycle): the lookup sees the pre-update value; the new value is visible next cycle.
- Prediction is purely combinational from PCF/InstrF, zero cycle latency. Training latency is 1 cycle.
- StallF does not enter this block. Training still occurs during a fetch stall.
- Reset (asynchronous, any time including mid-training): all counters go to WNT (01) and GHR goes to 0. Outputs then depend only on PCF/InstrF, so for a non-branch InstrF: PCSrc=00, PredTakenF=0.
- Execute inputs are assumed 0 for bubbles/flushed slots; the block does no flush qualification of its own.

Optional Feature:
Macro BP_GSHARE_EN.
- Defined:
  - A GHR_BITS global history register shifts in TakenE on every BranchE, LSB newest, updated at resolution time.
  - BhtIdxF = PCF[IDX_BITS+1:2] XOR zero-extended GHR.
  - Training still uses BhtIdxE, so the index is consistent with the one used at prediction.
- Undefined: no GHR flops exist and the index is PC bits only. Port list is identical in both builds.

Decomposition:
- Package bp_pkg holds:
  - opcode constants OP_BRANCH and OP_JAL;
  - enum bht_state_t {SNT,WNT,WT,ST};
  - PCSrc encoding constants PCSRC_SEQ=2'b00, PCSRC_PRED=2'b01, PCSRC_MISP=2'b10.
- One sub-module, bht: the counter array with combinational read port, synchronous saturating-update port and async active-low reset. branch_predictor keeps decode, target adders, GHR and PCSrc arbitration.

Test Plan:
- Reset: assert reset_n=0, then release; InstrF=BEQ at PCF=0x40, imm=+16 -> PCSrc=00, PredTakenF=0, BhtIdxF=16, TargetAddr=0x50.
- Training: two cycles BranchE=1, TakenE=1, BhtIdxE=16 -> counter 01->10->11; then BEQ at 0x40 -> PCSrc=01, TargetAddr=0x50. Three not-taken updates -> 11->10->01->00, with a fourth update holding at 00 (saturation).
- JAL at PCF=0x100, imm=-8 -> PCSrc=01, TargetAddr=0xF8, table unchanged. JAL at PCF=0xFFFFFFFC, imm=+8 -> TargetAddr=0x00000004 (wrap).
- Mispredict priority: predicted-taken branch in fetch while BranchE=1, TakenE=0, PredTakenE=1 -> PCSrc=10. JalrE=1 alone -> PCSrc=10.
- Collision: update and lookup on index 5 in the same cycle, counter 01, TakenE=1 -> lookup predicts not-taken; the next cycle predicts taken.
- BP_GSHARE_EN build: after branch history 1,0,1 (GHR=6'b000101), PCF=0x40 -> BhtIdxF=16^5=21. Mid-sequence reset_n pulse -> GHR=0 and BhtIdxF=16.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
package bp_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_PRED = 2'b01;
    localparam logic [1:0] PCSRC_MISP = 2'b10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_state_t sat_update(input bht_state_t s, input logic taken);
        bht_state_t r;
        r = s;
        if (taken) begin
            if (s != ST) r = bht_state_t'(2'(s + 2'd1));
        end else begin
            if (s != SNT) r = bht_state_t'(2'(s - 2'd1));
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Branch history table: 2-bit counters, combinational read, clocked saturating update.
module bht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output bht_state_t          rd_state_o,
    input  logic                upd_en_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    bht_state_t cnt_q [ENTRIES];
    bht_state_t cnt_d [ENTRIES];

    // Read sees the registered value, so a same-cycle update shows up next cycle.
    assign rd_state_o = cnt_q[rd_idx_i];

    // Next-state: only the resolving entry moves.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en_i) begin
            cnt_d[upd_idx_i] = sat_update(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

    // Counter array; every entry resets to weakly not-taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: decode, target generation, BHT lookup,
// Execute-stage training and redirect arbitration.
// Optional build macro BP_GSHARE_EN: XOR a global history register into the index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         PCF,
    input  logic [31:0]         InstrF,
    input  logic                BranchE,
    input  logic                TakenE,
    input  logic                PredTakenE,
    input  logic                JalrE,
    input  logic [IDX_BITS-1:0] BhtIdxE,
    output logic [1:0]          PCSrc,
    output logic [31:0]         TargetAddr,
    output logic                PredTakenF,
    output logic [IDX_BITS-1:0] BhtIdxF
);

    logic [6:0]          opcode;
    logic [31:0]         imm_b;
    logic [31:0]         imm_j;
    logic [IDX_BITS-1:0] pc_idx;
    logic                misp;
    bht_state_t          rd_state;

    assign opcode = InstrF[6:0];
    assign imm_b  = {{19{InstrF[31]}}, InstrF[31], InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};
    assign imm_j  = {{11{InstrF[31]}}, InstrF[31], InstrF[19:12], InstrF[20], InstrF[30:21], 1'b0};
    assign pc_idx = PCF[IDX_BITS+1:2];
    assign misp   = (BranchE && (TakenE != PredTakenE)) || JalrE;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    // History shifts in each resolved conditional branch, newest in the LSB.
    always_comb begin
        ghr_d = ghr_q;
        if (BranchE) begin
            ghr_d = GHR_BITS'({ghr_q, TakenE});
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign BhtIdxF = pc_idx ^ IDX_BITS'(ghr_q);
`else
    assign BhtIdxF = pc_idx;
`endif

    bht #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_idx_i    (BhtIdxF),
        .rd_state_o  (rd_state),
        .upd_en_i    (BranchE),
        .upd_idx_i   (BhtIdxE),
        .upd_taken_i (TakenE)
    );

    // Decode the fetched instruction into a prediction and its target.
    always_comb begin
        PredTakenF = 1'b0;
        TargetAddr = 32'(PCF + 32'd4);
        if (opcode == OP_BRANCH) begin
            PredTakenF = rd_state[1];
            TargetAddr = 32'(PCF + imm_b);
        end else if (opcode == OP_JAL) begin
            PredTakenF = 1'b1;
            TargetAddr = 32'(PCF + imm_j);
        end
    end

    // Execute redirect outranks any fetch prediction.
    always_comb begin
        PCSrc = PCSRC_SEQ;
        if (misp) begin
            PCSrc = PCSRC_MISP;
        end else if (PredTakenF) begin
            PCSrc = PCSRC_PRED;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

    localparam int unsigned IDX_BITS = 6;

    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] BEQ_M4  = 32'hFE00_0EE3;  // beq x0,x0,-4
    localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;  // jal x0,-8
    localparam logic [31:0] JAL_P8  = 32'h0080_006F;  // jal x0,+8
    localparam logic [31:0] NOP     = 32'h0000_0013;  // addi x0,x0,0

    logic                clk;
    logic                reset_n;
    logic [31:0]         PCF;
    logic [31:0]         InstrF;
    logic                BranchE;
    logic                TakenE;
    logic                PredTakenE;
    logic                JalrE;
    logic [IDX_BITS-1:0] BhtIdxE;
    logic [1:0]          PCSrc;
    logic [31:0]         TargetAddr;
    logic                PredTakenF;
    logic [IDX_BITS-1:0] BhtIdxF;

    int checks;
    int failures;

    branch_predictor #(
        .IDX_BITS (IDX_BITS),
        .GHR_BITS (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .BranchE    (BranchE),
        .TakenE     (TakenE),
        .PredTakenE (PredTakenE),
        .JalrE      (JalrE),
        .BhtIdxE    (BhtIdxE),
        .PCSrc      (PCSrc),
        .TargetAddr (TargetAddr),
        .PredTakenF (PredTakenF),
        .BhtIdxF    (BhtIdxF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One correctly predicted resolution on idx; leaves Execute idle 2 time units after the edge.
    task automatic train(input logic [IDX_BITS-1:0] idx, input logic taken);
        BranchE    = 1'b1;
        TakenE     = taken;
        PredTakenE = taken;
        BhtIdxE    = idx;
        @(posedge clk);
        #1;
        BranchE = 1'b0;
        TakenE  = 1'b0;
        PredTakenE = 1'b0;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        PCF        = 32'h40;
        InstrF     = BEQ_P16;
        BranchE    = 1'b0;
        TakenE     = 1'b0;
        PredTakenE = 1'b0;
        JalrE      = 1'b0;
        BhtIdxE    = '0;
        #2;
        chk("rst_pcsrc",  32'(PCSrc), 32'h0);
        chk("rst_pred",   32'(PredTakenF), 32'h0);
        chk("rst_idx",    32'(BhtIdxF), 32'd16);
        chk("rst_target", TargetAddr, 32'h50);
        @(negedge clk);
        reset_n = 1'b1;

`ifndef BP_GSHARE_EN
        // Taken training on idx 16; fetch of the same index sees the old counter.
        @(posedge clk);
        #1;
        BranchE = 1'b1; TakenE = 1'b1; PredTakenE = 1'b0; BhtIdxE = 6'd16;
        #1;
        chk("coll16_pcsrc", 32'(PCSrc), 32'h2);
        chk("coll16_pred",  32'(PredTakenF), 32'h0);
        @(posedge clk);
        #1;
        chk("wt_pred", 32'(PredTakenF), 32'h1);
        @(posedge clk);
        #1;
        BranchE = 1'b0; TakenE = 1'b0;
        #1;
        chk("st_pcsrc",  32'(PCSrc), 32'h1);
        chk("st_target", TargetAddr, 32'h50);

        // Extra taken must hold at ST.
        train(6'd16, 1'b1);
        // Mispredict in Execute beats a predicted-taken fetch.
        BranchE = 1'b1; TakenE = 1'b0; PredTakenE = 1'b1; BhtIdxE = 6'd16;
        #1;
        chk("misp_prio", 32'(PCSrc), 32'h2);
        @(posedge clk);
        #1;
        BranchE = 1'b0; PredTakenE = 1'b0;
        #1;
        chk("st_sat_then_dec", 32'(PredTakenF), 32'h1);
        train(6'd16, 1'b0);
        chk("wnt_pred", 32'(PredTakenF), 32'h0);
        train(6'd16, 1'b0);
        train(6'd16, 1'b0);
        train(6'd16, 1'b1);
        chk("snt_sat_inc", 32'(PredTakenF), 32'h0);
        train(6'd16, 1'b1);
        chk("snt_sat_inc2", 32'(PredTakenF), 32'h1);

        // JAL backward, then confirm its slot was not trained.
        PCF = 32'h100; InstrF = JAL_M8;
        #1;
        chk("jal_pcsrc",  32'(PCSrc), 32'h1);
        chk("jal_target", TargetAddr, 32'hF8);
        chk("jal_idx",    32'(BhtIdxF), 32'h0);
        @(posedge clk);
        #1;
        InstrF = BEQ_P16;
        #1;
        chk("jal_notrain", 32'(PredTakenF), 32'h0);
        chk("beq100_tgt",  TargetAddr, 32'h110);

        // JAL target wraps past 2^32.
        PCF = 32'hFFFF_FFFC; InstrF = JAL_P8;
        #1;
        chk("jal_wrap",     TargetAddr, 32'h4);
        chk("jal_wrap_idx", 32'(BhtIdxF), 32'd63);

        // Non-control instruction and lone JALR.
        PCF = 32'h200; InstrF = NOP;
        #1;
        chk("nop_pcsrc",  32'(PCSrc), 32'h0);
        chk("nop_target", TargetAddr, 32'h204);
        JalrE = 1'b1;
        #1;
        chk("jalr_pcsrc", 32'(PCSrc), 32'h2);
        JalrE = 1'b0;

        // Backward branch on the now weakly-taken idx 16.
        PCF = 32'h40; InstrF = BEQ_M4;
        #1;
        chk("beqm4_pcsrc",  32'(PCSrc), 32'h1);
        chk("beqm4_target", TargetAddr, 32'h3C);

        // Collision on idx 5: lookup sees WNT, next cycle sees WT.
        @(posedge clk);
        #1;
        PCF = 32'h14; InstrF = BEQ_P16;
        BranchE = 1'b1; TakenE = 1'b1; PredTakenE = 1'b1; BhtIdxE = 6'd5;
        #1;
        chk("coll5_pred",  32'(PredTakenF), 32'h0);
        chk("coll5_pcsrc", 32'(PCSrc), 32'h0);
        @(posedge clk);
        #1;
        BranchE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
        #1;
        chk("coll5_next",   32'(PredTakenF), 32'h1);
        chk("coll5_target", TargetAddr, 32'h24);

        // Asynchronous reset while a training update is pending.
        BranchE = 1'b1; TakenE = 1'b1; PredTakenE = 1'b1; BhtIdxE = 6'd5;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_pred", 32'(PredTakenF), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(PredTakenF), 32'h0);
        BranchE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        PCF = 32'h40;
        #1;
        chk("arst_idx16", 32'(PCSrc), 32'h0);
`else
        // History 1,0,1 -> GHR 000101 -> index 16^5.
        train(6'd0, 1'b1);
        train(6'd0, 1'b0);
        train(6'd0, 1'b1);
        chk("gs_idx21",  32'(BhtIdxF), 32'd21);
        chk("gs_pred21", 32'(PredTakenF), 32'h0);
        train(6'd0, 1'b1);
        chk("gs_idx27", 32'(BhtIdxF), 32'd27);
        reset_n = 1'b0;
        #1;
        chk("gs_rst_idx", 32'(BhtIdxF), 32'd16);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("gs_rst_hold", 32'(BhtIdxF), 32'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
